// File: rtl/dmem_store_buffer_if.sv
// Core data port and data-memory write/read port of the store buffer.
// slave is the buffer's view; master is the core/memory side.
interface dmem_store_buffer_if #(
   parameter int AW = 32,
   parameter int DW = 64
);
   logic [AW-1:0]   cpu_addr;
   logic            cpu_wr_en;
   logic [DW-1:0]   cpu_wdata;
   logic [DW/8-1:0] cpu_wmask;
   logic [DW-1:0]   cpu_rdata;
   logic            cpu_stall;
   logic            buf_empty;
   logic [AW-1:0]   mem_raddr;
   logic [DW-1:0]   mem_rdata;
   logic            mem_req;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_wdata;
   logic [DW/8-1:0] mem_wmask;
   logic            mem_ack;

   modport slave (
      input  cpu_addr, cpu_wr_en, cpu_wdata, cpu_wmask, mem_rdata, mem_ack,
      output cpu_rdata, cpu_stall, buf_empty, mem_raddr, mem_req,
             mem_addr, mem_wdata, mem_wmask
   );

   modport master (
      output cpu_addr, cpu_wr_en, cpu_wdata, cpu_wmask, mem_rdata, mem_ack,
      input  cpu_rdata, cpu_stall, buf_empty, mem_raddr, mem_req,
             mem_addr, mem_wdata, mem_wmask
   );
endinterface

// File: rtl/dmem_store_buffer.sv
// Store FIFO between the core data port and data memory, drained through req/ack,
// with per-byte youngest-first forwarding of buffered stores to loads.
module dmem_store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 64
) (
   input logic                 clk,
   input logic                 rst,
   dmem_store_buffer_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int LN = DW / 8;
   localparam int TW = AW - 3;

   localparam logic [0:0]  S_IDLE   = 1'b0;
   localparam logic [0:0]  S_REQ    = 1'b1;
   localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
   localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [TW-1:0] ent_addr [DEPTH];
   logic [DW-1:0] ent_data [DEPTH];
   logic [LN-1:0] ent_mask [DEPTH];

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW:0]   count;
   logic [0:0]    state;

   logic          full;
   logic          enq;
   logic          pop;

   logic [PW-1:0] fwd_idx  [DEPTH];
   logic          fwd_live [DEPTH];
   logic [DW-1:0] fwd_data;

   assign full = (count == CNT_FULL);
   assign enq  = bus.cpu_wr_en && !full;
   // mem_ack only counts while a request is outstanding
   assign pop  = (state == S_REQ) && bus.mem_ack;

   // Control: pointers, occupancy and drain FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         state <= S_IDLE;
      end else begin
         if (enq) tail <= tail + PTR_ONE;
         if (pop) head <= head + PTR_ONE;
         case ({enq, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
         case (state)
            S_IDLE:  if (count != '0) state <= S_REQ;
            S_REQ:   if (bus.mem_ack) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Entry storage: written at tail, never reset
   always_ff @(posedge clk) begin
      if (enq) begin
         ent_addr[tail] <= bus.cpu_addr[AW-1:3];
         ent_data[tail] <= bus.cpu_wdata;
         ent_mask[tail] <= bus.cpu_wmask;
      end
   end

   // Slot k is the k-th oldest entry; live when it lies inside the occupied window
   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         fwd_idx[k]  = head + PW'(k);
         fwd_live[k] = ((PW+1)'(k) < count) &&
                       (ent_addr[fwd_idx[k]] == bus.cpu_addr[AW-1:3]);
      end
   end

   // Walk oldest to youngest so younger matching lanes overwrite older ones
   always_comb begin
      fwd_data = bus.mem_rdata;
      for (int k = 0; k < DEPTH; k++) begin
         if (fwd_live[k]) begin
            for (int i = 0; i < LN; i++) begin
               if (ent_mask[fwd_idx[k]][i])
                  fwd_data[8*i +: 8] = ent_data[fwd_idx[k]][8*i +: 8];
            end
         end
      end
   end

   assign bus.cpu_rdata = fwd_data;
   assign bus.mem_raddr = bus.cpu_addr;
   assign bus.cpu_stall = bus.cpu_wr_en && full;
   assign bus.buf_empty = (count == '0);
   assign bus.mem_req   = (state == S_REQ);
   assign bus.mem_addr  = {ent_addr[head], 3'b000};
   assign bus.mem_wdata = ent_data[head];
   assign bus.mem_wmask = ent_mask[head];
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Scoreboard bench for dmem_store_buffer: stores are queued as expected memory
// writes and popped/compared when the buffer's write is acknowledged.
module tb_dmem_store_buffer;
   typedef struct packed {
      logic [31:0] a;
      logic [63:0] d;
      logic [7:0]  m;
   } wr_t;

   logic clk;
   logic rst;
   int   checks;
   int   fails;
   wr_t  sb[$];

   dmem_store_buffer_if #(.AW(32), .DW(64)) bus ();

   dmem_store_buffer #(.DEPTH(4), .AW(32), .DW(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_store(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
      bus.cpu_addr  = a;
      bus.cpu_wdata = d;
      bus.cpu_wmask = m;
      bus.cpu_wr_en = 1'b1;
   endtask

   task automatic push_exp(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
      wr_t w;
      w.a = {a[31:3], 3'b000};
      w.d = d;
      w.m = m;
      sb.push_back(w);
   endtask

   // Acknowledge every queued write in order, checking payload and the idle gap
   task automatic drain_all(input string tag);
      int n;
      while (sb.size() > 0) begin
         n = 0;
         while (bus.mem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
         end
         checks++;
         if (bus.mem_req !== 1'b1) begin
            fails++;
            $display("FAIL %s_req_timeout: mem_req=%b required 1", tag, bus.mem_req);
            sb.delete();
            return;
         end
         checks++;
         if (bus.mem_addr !== sb[0].a || bus.mem_wdata !== sb[0].d || bus.mem_wmask !== sb[0].m) begin
            fails++;
            $display("FAIL %s_payload: got %h/%h/%h required %h/%h/%h", tag,
                     bus.mem_addr, bus.mem_wdata, bus.mem_wmask, sb[0].a, sb[0].d, sb[0].m);
         end
         bus.mem_ack = 1'b1;
         tick();
         bus.mem_ack = 1'b0;
         void'(sb.pop_front());
         checks++;
         if (bus.mem_req !== 1'b0) begin
            fails++;
            $display("FAIL %s_idle_gap: mem_req=%b required 0", tag, bus.mem_req);
         end
      end
      tick();
      checks++;
      if (bus.buf_empty !== 1'b1) begin
         fails++;
         $display("FAIL %s_empty: buf_empty=%b required 1", tag, bus.buf_empty);
      end
   endtask

   task automatic test_reset();
      rst           = 1'b1;
      bus.cpu_wr_en = 1'b1;
      bus.cpu_addr  = 32'h0;
      bus.cpu_wdata = '0;
      bus.cpu_wmask = '0;
      bus.mem_rdata = '0;
      bus.mem_ack   = 1'b0;
      tick();
      tick();
      checks++;
      if (bus.mem_req !== 1'b0 || bus.buf_empty !== 1'b1 || bus.cpu_stall !== 1'b0) begin
         fails++;
         $display("FAIL reset_state: req=%b empty=%b stall=%b required 0/1/0",
                  bus.mem_req, bus.buf_empty, bus.cpu_stall);
      end
      bus.cpu_wr_en = 1'b0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single_store();
      drive_store(32'h100, 64'h1122334455667788, 8'hFF);
      push_exp(32'h100, 64'h1122334455667788, 8'hFF);
      tick();
      bus.cpu_wr_en = 1'b0;
      checks++;
      if (bus.mem_req !== 1'b0 || bus.buf_empty !== 1'b0) begin
         fails++;
         $display("FAIL t1_after_enq: req=%b empty=%b required 0/0", bus.mem_req, bus.buf_empty);
      end
      tick();
      checks++;
      if (bus.mem_req !== 1'b1) begin
         fails++;
         $display("FAIL t1_req_latency: mem_req=%b required 1", bus.mem_req);
      end
      drain_all("t1");
   endtask

   task automatic test_full_stall();
      logic [63:0] d;
      for (int k = 0; k < 4; k++) begin
         d = {$urandom, $urandom};
         drive_store(32'h400 + 32'(8*k), d, 8'hFF);
         #1;
         checks++;
         if (bus.cpu_stall !== 1'b0) begin
            fails++;
            $display("FAIL t2_accept%0d: cpu_stall=%b required 0", k, bus.cpu_stall);
         end
         push_exp(32'h400 + 32'(8*k), d, 8'hFF);
         tick();
      end
      d = 64'h5555_6666_7777_8888;
      drive_store(32'h420, d, 8'hF0);
      #1;
      checks++;
      if (bus.cpu_stall !== 1'b1) begin
         fails++;
         $display("FAIL t2_full_stall: cpu_stall=%b required 1", bus.cpu_stall);
      end
      tick();
      bus.mem_ack = 1'b1;
      #1;
      checks++;
      if (bus.cpu_stall !== 1'b1) begin
         fails++;
         $display("FAIL t2_stall_on_pop: cpu_stall=%b required 1", bus.cpu_stall);
      end
      checks++;
      if (bus.mem_addr !== sb[0].a || bus.mem_wdata !== sb[0].d) begin
         fails++;
         $display("FAIL t2_head_payload: got %h/%h required %h/%h",
                  bus.mem_addr, bus.mem_wdata, sb[0].a, sb[0].d);
      end
      tick();
      void'(sb.pop_front());
      bus.mem_ack = 1'b0;
      #1;
      checks++;
      if (bus.cpu_stall !== 1'b0) begin
         fails++;
         $display("FAIL t2_stall_release: cpu_stall=%b required 0", bus.cpu_stall);
      end
      push_exp(32'h420, d, 8'hF0);
      tick();
      bus.cpu_wr_en = 1'b0;
      drain_all("t2");
   endtask

   task automatic test_forward_merge();
      bus.mem_rdata = {8{8'hCC}};
      drive_store(32'h200, {4{16'hAAAA}}, 8'h0F);
      push_exp(32'h200, {4{16'hAAAA}}, 8'h0F);
      tick();
      drive_store(32'h204, {4{16'hBBBB}}, 8'h03);
      push_exp(32'h204, {4{16'hBBBB}}, 8'h03);
      #1;
      checks++;
      if (bus.cpu_rdata !== 64'hCCCCCCCCAAAAAAAA) begin
         fails++;
         $display("FAIL t3_same_cycle_invisible: cpu_rdata=%h required CCCCCCCCAAAAAAAA", bus.cpu_rdata);
      end
      tick();
      bus.cpu_wr_en = 1'b0;
      bus.cpu_addr  = 32'h200;
      #1;
      checks++;
      if (bus.cpu_rdata !== 64'hCCCCCCCCAAAABBBB) begin
         fails++;
         $display("FAIL t3_youngest_wins: cpu_rdata=%h required CCCCCCCCAAAABBBB", bus.cpu_rdata);
      end
      checks++;
      if (bus.mem_raddr !== 32'h200) begin
         fails++;
         $display("FAIL t3_raddr: mem_raddr=%h required 00000200", bus.mem_raddr);
      end
      drain_all("t3");
   endtask

   task automatic test_random_drain();
      int acked;
      int budget;
      fork
         begin
            logic [63:0] d;
            logic [7:0]  m;
            logic        exp_stall;
            for (int s = 0; s < 10;) begin
               d = {$urandom, $urandom};
               m = 8'($urandom);
               drive_store(32'h1000 + 32'(8*s), d, m);
               #1;
               exp_stall = (sb.size() == 4);
               checks++;
               if (bus.cpu_stall !== exp_stall) begin
                  fails++;
                  $display("FAIL t4_stall%0d: cpu_stall=%b required %b", s, bus.cpu_stall, exp_stall);
               end
               if (!exp_stall) begin
                  push_exp(32'h1000 + 32'(8*s), d, m);
                  s++;
               end
               @(posedge clk);
               #1;
               if ($urandom_range(0, 3) == 0) begin
                  bus.cpu_wr_en = 1'b0;
                  tick();
               end
            end
            bus.cpu_wr_en = 1'b0;
         end
         begin
            acked  = 0;
            budget = 0;
            while (acked < 10 && budget < 400) begin
               budget++;
               if (bus.mem_req === 1'b1) begin
                  repeat ($urandom_range(0, 3)) tick();
                  checks++;
                  if (sb.size() == 0) begin
                     fails++;
                     $display("FAIL t4_spurious_req: mem_addr=%h required no request", bus.mem_addr);
                  end else if (bus.mem_addr !== sb[0].a || bus.mem_wdata !== sb[0].d ||
                               bus.mem_wmask !== sb[0].m || bus.mem_req !== 1'b1) begin
                     fails++;
                     $display("FAIL t4_write%0d: got %h/%h/%h required %h/%h/%h", acked,
                              bus.mem_addr, bus.mem_wdata, bus.mem_wmask, sb[0].a, sb[0].d, sb[0].m);
                  end
                  bus.mem_ack = 1'b1;
                  @(posedge clk);
                  if (sb.size() > 0) void'(sb.pop_front());
                  #1;
                  bus.mem_ack = 1'b0;
                  acked++;
               end else begin
                  tick();
               end
            end
            checks++;
            if (acked != 10) begin
               fails++;
               $display("FAIL t4_drain_timeout: writes=%0d required 10", acked);
            end
         end
      join
      tick();
      checks++;
      if (bus.buf_empty !== 1'b1 || sb.size() != 0) begin
         fails++;
         $display("FAIL t4_final_empty: buf_empty=%b left=%0d required 1/0", bus.buf_empty, sb.size());
      end
   endtask

   task automatic test_reset_midflight();
      for (int k = 0; k < 3; k++) begin
         drive_store(32'h800 + 32'(8*k), {2{$urandom}}, 8'hFF);
         tick();
      end
      bus.cpu_wr_en = 1'b0;
      checks++;
      if (bus.mem_req !== 1'b1 || bus.buf_empty !== 1'b0) begin
         fails++;
         $display("FAIL t5_pre_reset: req=%b empty=%b required 1/0", bus.mem_req, bus.buf_empty);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (bus.mem_req !== 1'b0 || bus.buf_empty !== 1'b1) begin
         fails++;
         $display("FAIL t5_reset_flush: req=%b empty=%b required 0/1", bus.mem_req, bus.buf_empty);
      end
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      tick();
      checks++;
      if (bus.mem_req !== 1'b0 || bus.buf_empty !== 1'b1) begin
         fails++;
         $display("FAIL t5_ack_ignored: req=%b empty=%b required 0/1", bus.mem_req, bus.buf_empty);
      end
      drive_store(32'h508, 64'hDEAD_BEEF_0BAD_F00D, 8'h3C);
      push_exp(32'h508, 64'hDEAD_BEEF_0BAD_F00D, 8'h3C);
      tick();
      bus.cpu_wr_en = 1'b0;
      drain_all("t5");
   endtask

   task automatic test_no_match_load();
      drive_store(32'h100, 64'h0102030405060708, 8'hFF);
      push_exp(32'h100, 64'h0102030405060708, 8'hFF);
      tick();
      bus.cpu_wr_en = 1'b0;
      tick();
      bus.cpu_addr  = 32'h300;
      bus.mem_rdata = {$urandom, $urandom};
      #1;
      checks++;
      if (bus.mem_req !== 1'b1 || bus.cpu_rdata !== bus.mem_rdata) begin
         fails++;
         $display("FAIL t6_passthrough: req=%b cpu_rdata=%h required 1/%h",
                  bus.mem_req, bus.cpu_rdata, bus.mem_rdata);
      end
      checks++;
      if (bus.mem_raddr !== 32'h300) begin
         fails++;
         $display("FAIL t6_raddr: mem_raddr=%h required 00000300", bus.mem_raddr);
      end
      bus.cpu_addr = 32'h104;
      #1;
      checks++;
      if (bus.cpu_rdata !== 64'h0102030405060708) begin
         fails++;
         $display("FAIL t6_head_forward: cpu_rdata=%h required 0102030405060708", bus.cpu_rdata);
      end
      drain_all("t6");
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      test_reset();
      test_single_store();
      test_full_stall();
      test_forward_merge();
      test_random_drain();
      test_reset_midflight();
      test_no_match_load();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation time exceeded bound");
      $fatal(1, "timeout");
   end
endmodule
